// File: rtl/exec_unit.sv
// exec_unit -- small integer execution unit with an ARM-style NZCV flags
// register. Single-cycle ALU ops and an optional iterative shift-add MUL.
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   in_valid   in   operation request
//   in_ready   out  high only while idle; request accepted on in_valid && in_ready
//   op         in   4-bit opcode (0 ADD,1 SUB,2 AND,3 ORR,4 EOR,5 ADC,6 SBC,
//                   7 RSB,8 RSC,9 MUL, 10-15 undefined)
//   a, b       in   WIDTH-bit operands
//   set_flags  in   update NZCV when the result is loaded
//   out_valid  out  registered, result available
//   out_ready  in   consumer accepts result
//   result     out  registered WIDTH-bit result
//   flags      out  registered {N,Z,C,V}

module exec_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSB = 4'd7;
  localparam logic [3:0] OP_RSC = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_outValid;
  logic [WIDTH-1:0] r_mulA;
  logic [WIDTH-1:0] r_mulB;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_setFlags;

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_isArith;
  logic             w_isLogic;
  logic             w_isMul;
  logic [WIDTH-1:0] w_logicRes;
  logic [WIDTH-1:0] w_aluRes;
  logic [3:0]       w_aluFlags;
  logic             w_ovf;
  logic [WIDTH-1:0] w_accNext;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_outValid;
  assign result    = r_result;
  assign flags     = r_flags;

  // All adder ops reduce to x + y + cin; subtracts feed the inverted operand
  // so C comes out as "no borrow". C for ADC/SBC/RSC is the live flags
  // register, which is exactly the value in the acceptance cycle.
  always_comb begin
    w_x        = '0;
    w_y        = '0;
    w_cin      = 1'b0;
    w_isArith  = 1'b0;
    w_isLogic  = 1'b0;
    w_logicRes = '0;
    case (op)
      OP_ADD: begin w_x = a; w_y = b;  w_cin = 1'b0;       w_isArith = 1'b1; end
      OP_SUB: begin w_x = a; w_y = ~b; w_cin = 1'b1;       w_isArith = 1'b1; end
      OP_ADC: begin w_x = a; w_y = b;  w_cin = r_flags[1]; w_isArith = 1'b1; end
      OP_SBC: begin w_x = a; w_y = ~b; w_cin = r_flags[1]; w_isArith = 1'b1; end
      OP_RSB: begin w_x = b; w_y = ~a; w_cin = 1'b1;       w_isArith = 1'b1; end
      OP_RSC: begin w_x = b; w_y = ~a; w_cin = r_flags[1]; w_isArith = 1'b1; end
      OP_AND: begin w_logicRes = a & b; w_isLogic = 1'b1; end
      OP_ORR: begin w_logicRes = a | b; w_isLogic = 1'b1; end
      OP_EOR: begin w_logicRes = a ^ b; w_isLogic = 1'b1; end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};

  // Signed overflow: both adder inputs share a sign that the sum does not.
  assign w_ovf = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);

  assign w_isMul = MUL_EN && (op == OP_MUL);

  // Undefined ops (including MUL when disabled) fall through to result 0.
  always_comb begin
    w_aluRes   = '0;
    w_aluFlags = r_flags;
    if (w_isArith) begin
      w_aluRes   = w_sum[WIDTH-1:0];
      w_aluFlags = {w_sum[WIDTH-1], (w_sum[WIDTH-1:0] == '0), w_sum[WIDTH], w_ovf};
    end else if (w_isLogic) begin
      w_aluRes   = w_logicRes;
      w_aluFlags = {w_logicRes[WIDTH-1], (w_logicRes == '0), r_flags[1:0]};
    end
  end

  // One multiplier bit per cycle; multiplicand shifts left, multiplier right.
  assign w_accNext = r_mulB[0] ? (r_acc + r_mulA) : r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_result   <= '0;
      r_flags    <= 4'b0000;
      r_outValid <= 1'b0;
      r_mulA     <= '0;
      r_mulB     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_setFlags <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (w_isMul) begin
              r_mulA     <= a;
              r_mulB     <= b;
              r_acc      <= '0;
              r_cnt      <= '0;
              r_setFlags <= set_flags;
              r_state    <= MUL;
            end else begin
              r_result   <= w_aluRes;
              if (set_flags && (w_isArith || w_isLogic))
                r_flags <= w_aluFlags;
              r_outValid <= 1'b1;
              r_state    <= DONE;
            end
          end
        end
        MUL: begin
          r_acc  <= w_accNext;
          r_mulA <= r_mulA << 1;
          r_mulB <= r_mulB >> 1;
          r_cnt  <= r_cnt + CW'(1);
          // The last bit is folded in on the same edge that loads the result.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_result <= w_accNext;
            if (r_setFlags)
              r_flags <= {w_accNext[WIDTH-1], (w_accNext == '0), r_flags[1:0]};
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit -- directed, table-driven bench for exec_unit (WIDTH=32).
// Vectors run in order and the flags register carries between them, so each
// expected NZCV value depends on the vector before it.

module tb_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        set_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int totalChecks = 0;
  int passCount   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sf;
    logic [31:0] expRes;
    logic [3:0]  expFlags;
    int          expLat;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  exec_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Issues one request, scrambles the inputs after acceptance, and measures
  // cycles from the acceptance edge until out_valid is seen.
  task automatic applyStimulus(input logic [3:0] iOp, input logic [31:0] iA, input logic [31:0] iB,
                               input logic iSf, output int lat);
    @(negedge clk);
    checkOutput("inReadyIdle", 32'(in_ready), 32'd1);
    op = iOp; a = iA; b = iB; set_flags = iSf; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 4'd2; set_flags = ~iSf;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Completes the output handshake and confirms the return to idle.
  task automatic finishTransaction();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("outValidDrop", 32'(out_valid), 32'd0);
    checkOutput("inReadyBack", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic sawValid;

    // op, a, b, sf, expRes, expFlags, latency
    vecs[0]  = '{4'd0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 4'b0110, 1};
    vecs[1]  = '{4'd0, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 4'b1001, 1};
    vecs[2]  = '{4'd1, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 4'b1000, 1};
    vecs[3]  = '{4'd2, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 32'h00000000, 4'b0100, 1};
    vecs[4]  = '{4'd3, 32'h80000000, 32'h00000001, 1'b1, 32'h80000001, 4'b1000, 1};
    vecs[5]  = '{4'd0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 4'b0110, 1};
    vecs[6]  = '{4'd4, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'hFFFFFFFF, 4'b1010, 1};
    vecs[7]  = '{4'd8, 32'h00000001, 32'h00000005, 1'b1, 32'h00000004, 4'b0010, 1};
    vecs[8]  = '{4'd5, 32'h00000001, 32'h00000002, 1'b0, 32'h00000004, 4'b0010, 1};
    vecs[9]  = '{4'd6, 32'h0000000A, 32'h00000003, 1'b1, 32'h00000007, 4'b0010, 1};
    vecs[10] = '{4'd1, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 4'b1000, 1};
    vecs[11] = '{4'd8, 32'h00000001, 32'h00000005, 1'b1, 32'h00000003, 4'b0010, 1};
    vecs[12] = '{4'd5, 32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 4'b0011, 1};
    vecs[13] = '{4'd7, 32'h00000003, 32'h0000000A, 1'b1, 32'h00000007, 4'b0010, 1};
    vecs[14] = '{4'd1, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 4'b1000, 1};
    vecs[15] = '{4'd6, 32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 4'b1000, 1};
    vecs[16] = '{4'd12, 32'h00000003, 32'h00000004, 1'b1, 32'h00000000, 4'b1000, 1};
    vecs[17] = '{4'd0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 4'b0110, 1};
    vecs[18] = '{4'd9, 32'h0000FFFF, 32'h00010001, 1'b1, 32'hFFFFFFFF, 4'b1010, 33};
    vecs[19] = '{4'd9, 32'h00000007, 32'h00000006, 1'b0, 32'h0000002A, 4'b1010, 33};
    vecs[20] = '{4'd9, 32'h00000000, 32'h00012345, 1'b1, 32'h00000000, 4'b0110, 33};
    vecs[21] = '{4'd9, 32'h80000001, 32'h00000003, 1'b1, 32'h80000003, 4'b1010, 33};

    reset = 1'b1; in_valid = 1'b0; op = 4'd0; a = '0; b = '0;
    set_flags = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstResult", result, 32'd0);
    checkOutput("rstFlags", {28'd0, flags}, 32'd0);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstInReady", 32'(in_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sf, lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d_result", i), result, vecs[i].expRes);
      checkOutput($sformatf("vec%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].expFlags});
      finishTransaction();
    end

    // Output stall: ADD 2+3 from flags 1010 gives 5 / 0000; hold out_ready low
    // and pulse in_valid with a different op, which must be ignored.
    applyStimulus(4'd0, 32'd2, 32'd3, 1'b1, lat);
    checkOutput("stallLatency", 32'(lat), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 4'd1; a = 32'd100; b = 32'd1; set_flags = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput($sformatf("stall%0d_result", k), result, 32'd5);
      checkOutput($sformatf("stall%0d_flags", k), {28'd0, flags}, 32'd0);
      checkOutput($sformatf("stall%0d_inReady", k), 32'(in_ready), 32'd0);
      checkOutput($sformatf("stall%0d_outValid", k), 32'(out_valid), 32'd1);
    end
    finishTransaction();

    // Abort a MUL with reset after 10 cycles; flags are nonzero beforehand.
    applyStimulus(4'd0, 32'h7FFFFFFF, 32'd1, 1'b1, lat);
    checkOutput("preAbortFlags", {28'd0, flags}, 32'h9);
    finishTransaction();
    @(negedge clk);
    op = 4'd9; a = 32'h0000FFFF; b = 32'h00010001; set_flags = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abortOutValid", 32'(out_valid), 32'd0);
    checkOutput("abortFlags", {28'd0, flags}, 32'd0);
    checkOutput("abortResult", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("abortInReady", 32'(in_ready), 32'd1);
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("abortNoResult", 32'(sawValid), 32'd0);

    // Reset coinciding with an acceptance must win.
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'h7FFFFFFF; b = 32'd1; set_flags = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstWinsOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstWinsFlags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstWinsInReady", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
